sync_updown_counter: RTL and testbench

Parametrised synchronous up/down counter and the general-purpose successor to the team's fixed 4-bit up counter. Adds configurable width and modulus, count direction, enable, synchronous clear, parallel load, and wrap or saturate mode. Provides terminal-count and sticky overflow status for timers, event counters and address generators elsewhere in the design.

---
 rtl/sync_updown_counter.sv | 76 +++++++
 tb/tb_sync_updown_counter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sync_updown_counter.sv
// Parametrised up/down counter with a programmable modulus, a wrap or saturate boundary mode,
// parallel load, a registered terminal-count pulse and a sticky overflow flag.
module sync_updown_counter #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
  parameter bit               SATURATE  = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_nxt;
  logic             tc_nxt;
  logic             ovf_nxt;

  assign at_max = (q == MAX_VAL);
  assign at_min = (q == '0);

  // Boundaries are detected by comparison rather than by carry, so a full-range
  // modulus and a short modulus take the same path.
  always_comb begin
    q_nxt   = q;
    tc_nxt  = 1'b0;
    ovf_nxt = ovf;
    if (clear) begin
      q_nxt   = RESET_VAL;
      ovf_nxt = 1'b0;
    end else if (load) begin
      q_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      if (up_dn) begin
        if (at_max) begin
          tc_nxt  = 1'b1;
          ovf_nxt = 1'b1;
          if (!SATURATE) q_nxt = '0;
        end else begin
          q_nxt = q + ONE;
        end
      end else begin
        if (at_min) begin
          tc_nxt  = 1'b1;
          ovf_nxt = 1'b1;
          if (!SATURATE) q_nxt = MAX_VAL;
        end else begin
          q_nxt = q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q   <= RESET_VAL;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      q   <= q_nxt;
      tc  <= tc_nxt;
      ovf <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_sync_updown_counter.sv
// Bench for sync_updown_counter: three configurations share one stimulus stream;
// each expected entry names the instance it applies to.
module tb_sync_updown_counter;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] q_a, q_b, q_c;
  logic       tc_a, tc_b, tc_c;
  logic       ovf_a, ovf_b, ovf_c;
  logic       mx_a, mx_b, mx_c;
  logic       mn_a, mn_b, mn_c;

  // entry = {dut[1:0], q[3:0], tc, ovf, at_max, at_min}
  logic [9:0] exp_q[$];
  int         n_checks;
  int         n_pass;

  sync_updown_counter #(.WIDTH(4), .MAX_VAL(4'd15), .SATURATE(1'b0), .RESET_VAL(4'd0)) u_a (
    .clk(clk), .reset(reset), .clear(clear), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .q(q_a), .tc(tc_a), .ovf(ovf_a), .at_max(mx_a), .at_min(mn_a));

  sync_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0), .RESET_VAL(4'd0)) u_b (
    .clk(clk), .reset(reset), .clear(clear), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .q(q_b), .tc(tc_b), .ovf(ovf_b), .at_max(mx_b), .at_min(mn_b));

  sync_updown_counter #(.WIDTH(4), .MAX_VAL(4'd12), .SATURATE(1'b1), .RESET_VAL(4'd0)) u_c (
    .clk(clk), .reset(reset), .clear(clear), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .q(q_c), .tc(tc_c), .ovf(ovf_c), .at_max(mx_c), .at_min(mn_c));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want end of stimulus");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [3:0] max_of(input int dut);
    case (dut)
      0:       max_of = 4'd15;
      1:       max_of = 4'd9;
      default: max_of = 4'd12;
    endcase
  endfunction

  // driver tasks
  task automatic push(input int dut, input logic [3:0] eq, input logic etc, input logic eovf);
    logic [1:0] d;
    d = dut[1:0];
    exp_q.push_back({d, eq, etc, eovf, (eq == max_of(dut)), (eq == 4'd0)});
  endtask

  task automatic step(input int dut, input logic c, input logic l, input logic [3:0] lv,
                      input logic e, input logic u,
                      input logic [3:0] eq, input logic etc, input logic eovf);
    @(negedge clk);
    clear    = c;
    load     = l;
    load_val = lv;
    en       = e;
    up_dn    = u;
    push(dut, eq, etc, eovf);
  endtask

  // Raises reset between edges; the expected reset state is checked before the next edge.
  task automatic async_reset();
    @(negedge clk);
    #2;
    push(0, 4'd0, 1'b0, 1'b0);
    reset = 1'b1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b0;
    clear = 1'b0;
    load  = 1'b0;
    push(0, 4'd0, 1'b0, 1'b0);
  endtask

  // scoreboard monitor
  always @(posedge clk or posedge reset) begin
    logic [9:0] e;
    logic [7:0] act;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e[9:8])
        2'd0:    act = {q_a, tc_a, ovf_a, mx_a, mn_a};
        2'd1:    act = {q_b, tc_b, ovf_b, mx_b, mn_b};
        default: act = {q_c, tc_c, ovf_c, mx_c, mn_c};
      endcase
      n_checks++;
      if (act === e[7:0]) begin
        n_pass++;
      end else begin
        $display("FAIL chk%0d dut%0d @%0t: got q=%0d tc=%b ovf=%b at_max=%b at_min=%b, want q=%0d tc=%b ovf=%b at_max=%b at_min=%b",
                 n_checks, e[9:8], $time, act[7:4], act[3], act[2], act[1], act[0],
                 e[7:4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  // stimulus
  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    clear    = 1'b0;
    en       = 1'b0;
    up_dn    = 1'b0;
    load     = 1'b0;
    load_val = 4'd0;
    repeat (3) @(posedge clk);

    // reset state, then full-range wrap-around count
    step(0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      logic [3:0] eq;
      eq = 4'(k % 16);
      step(0, 0, 0, 4'd0, 1, 1, eq, (k == 16), (k >= 16));
    end

    // modulus-10 down count through zero
    step(1, 1, 0, 4'd0, 0, 0, 4'd0, 0, 0);
    step(1, 0, 1, 4'd2, 0, 0, 4'd2, 0, 0);
    step(1, 0, 0, 4'd0, 1, 0, 4'd1, 0, 0);
    step(1, 0, 0, 4'd0, 1, 0, 4'd0, 0, 0);
    step(1, 0, 0, 4'd0, 1, 0, 4'd9, 1, 1);
    step(1, 0, 0, 4'd0, 1, 0, 4'd8, 0, 1);

    // saturate at MAX_VAL=12, then turn around; then saturate at zero
    step(2, 1, 0, 4'd0, 0, 0, 4'd0, 0, 0);
    step(2, 0, 1, 4'd11, 0, 0, 4'd11, 0, 0);
    step(2, 0, 0, 4'd0, 1, 1, 4'd12, 0, 0);
    step(2, 0, 0, 4'd0, 1, 1, 4'd12, 1, 1);
    step(2, 0, 0, 4'd0, 1, 1, 4'd12, 1, 1);
    step(2, 0, 0, 4'd0, 1, 1, 4'd12, 1, 1);
    step(2, 0, 0, 4'd0, 1, 0, 4'd11, 0, 1);
    step(2, 1, 0, 4'd0, 0, 0, 4'd0, 0, 0);
    step(2, 0, 0, 4'd0, 1, 0, 4'd0, 1, 1);

    // priority clear > load > en, clamp, load keeps ovf
    step(1, 1, 1, 4'd5, 1, 1, 4'd0, 0, 0);
    step(1, 0, 1, 4'd14, 1, 1, 4'd9, 0, 0);
    step(1, 0, 0, 4'd0, 1, 1, 4'd0, 1, 1);
    step(1, 0, 1, 4'd3, 1, 1, 4'd3, 0, 1);

    // asynchronous reset mid-count
    step(0, 1, 0, 4'd0, 0, 0, 4'd0, 0, 0);
    step(0, 0, 1, 4'd15, 0, 0, 4'd15, 0, 0);
    step(0, 0, 0, 4'd0, 1, 1, 4'd0, 1, 1);
    step(0, 0, 1, 4'd6, 0, 0, 4'd6, 0, 1);
    step(0, 0, 0, 4'd0, 1, 1, 4'd7, 0, 1);
    async_reset();
    step(0, 0, 0, 4'd0, 1, 1, 4'd0, 0, 0);
    step(0, 0, 0, 4'd0, 1, 1, 4'd0, 0, 0);
    release_reset();
    step(0, 0, 0, 4'd0, 1, 1, 4'd1, 0, 0);

    // hold at MAX_VAL, then up/down toggle around zero
    step(0, 0, 1, 4'd15, 0, 0, 4'd15, 0, 0);
    repeat (5) step(0, 0, 0, 4'd0, 0, 1, 4'd15, 0, 0);
    step(0, 1, 0, 4'd0, 0, 0, 4'd0, 0, 0);
    step(0, 0, 0, 4'd0, 1, 1, 4'd1, 0, 0);
    step(0, 0, 0, 4'd0, 1, 0, 4'd0, 0, 0);
    step(0, 0, 0, 4'd0, 1, 1, 4'd1, 0, 0);

    // drain and report
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
      n_checks += exp_q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
